// File: rtl/pwr_seq_pkg.sv
// Shared types for the power-enable sequencer.
// Mode encoding, FSM states and the default module count.
package pwr_seq_pkg;

    localparam int NUM_MODULES_DEF = 32;

    typedef enum logic [1:0] {
        MODE_THERMO = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_ALLON  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_WALK  = 3'd3,
        ST_ALLON = 3'd4
    } state_e;

endpackage

// File: rtl/pwr_en_sequencer_dwell_timer.sv
// Dwell countdown: load takes value-1, expire is high while at 0.
// Counts down without wrapping; value is expected to be >= 1.
module dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk100m,
    input  logic               rstn,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value - DWELL_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pwr_en_sequencer.sv
// Power-enable sequencer: thermometer, walking-one and all-on
// patterns, each held for a latched dwell, with stop abort.
module pwr_en_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES = NUM_MODULES_DEF,
    parameter int DWELL_W     = 32
) (
    input  logic                           clk100m,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           stop,
    input  logic [1:0]                     mode,
    input  logic [DWELL_W-1:0]             dwell_cycles,
    output logic [NUM_MODULES-1:0]         pwr_en_out,
    output logic [$clog2(NUM_MODULES):0]   active_count,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = $clog2(NUM_MODULES) + 1;
    localparam logic [CW-1:0] K_N = CW'(NUM_MODULES);
    localparam logic [CW-1:0] K_1 = CW'(1);
    localparam logic [NUM_MODULES-1:0] ONE = NUM_MODULES'(1);

    state_e             state;
    mode_e              mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CW-1:0]      k;
    logic               accept;
    logic               expire;
    logic               last_pat;
    logic               t_load;
    logic [DWELL_W-1:0] t_value;
    logic [DWELL_W-1:0] dwell_clamp;

    function automatic logic [NUM_MODULES-1:0] thermo(input logic [CW-1:0] n);
        return ~({NUM_MODULES{1'b1}} << n);
    endfunction

    assign dwell_clamp = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    assign accept = (state == ST_IDLE) && start && !stop &&
                    (mode != MODE_RSVD);

    // Detect the final pattern of the running sequence.
    always_comb begin
        last_pat = 1'b0;
        unique case (mode_q)
            MODE_THERMO: last_pat = ((state == ST_DOWN) && (k == K_1)) ||
                                    ((NUM_MODULES == 1) && (state == ST_UP));
            MODE_WALK:   last_pat = (k == K_N - K_1);
            MODE_ALLON:  last_pat = 1'b1;
            default:     last_pat = 1'b1;
        endcase
    end

    assign t_load  = accept || ((state != ST_IDLE) && expire && !stop);
    assign t_value = (state == ST_IDLE) ? dwell_clamp : dwell_q;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk100m (clk100m),
        .rstn    (rstn),
        .load    (t_load),
        .value   (t_value),
        .expire  (expire)
    );

    // Sequencer FSM with registered pattern, popcount and status.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_THERMO;
            dwell_q      <= '0;
            k            <= '0;
            pwr_en_out   <= '0;
            active_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    mode_q  <= mode_e'(mode);
                    dwell_q <= dwell_clamp;
                    busy    <= 1'b1;
                    unique case (mode_e'(mode))
                        MODE_THERMO: begin
                            state        <= ST_UP;
                            k            <= K_1;
                            pwr_en_out   <= ONE;
                            active_count <= K_1;
                        end
                        MODE_WALK: begin
                            state        <= ST_WALK;
                            k            <= '0;
                            pwr_en_out   <= ONE;
                            active_count <= K_1;
                        end
                        default: begin
                            state        <= ST_ALLON;
                            pwr_en_out   <= '1;
                            active_count <= K_N;
                        end
                    endcase
                end
            end else if (stop) begin
                state        <= ST_IDLE;
                pwr_en_out   <= '0;
                active_count <= '0;
                busy         <= 1'b0;
            end else if (expire) begin
                if (last_pat) begin
                    state        <= ST_IDLE;
                    pwr_en_out   <= '0;
                    active_count <= '0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                end else begin
                    unique case (state)
                        ST_UP: begin
                            if (k == K_N) begin
                                state        <= ST_DOWN;
                                k            <= K_N - K_1;
                                pwr_en_out   <= thermo(K_N - K_1);
                                active_count <= K_N - K_1;
                            end else begin
                                k            <= k + K_1;
                                pwr_en_out   <= thermo(k + K_1);
                                active_count <= k + K_1;
                            end
                        end
                        ST_DOWN: begin
                            k            <= k - K_1;
                            pwr_en_out   <= thermo(k - K_1);
                            active_count <= k - K_1;
                        end
                        ST_WALK: begin
                            k          <= k + K_1;
                            pwr_en_out <= ONE << (k + K_1);
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Directed testbench for pwr_en_sequencer.
// Outputs sampled on the falling edge; cycle n is n edges after start.
module tb_pwr_en_sequencer;

    logic        clk100m = 1'b0;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] dwell_cycles;
    logic [31:0] pwr_en_out;
    logic [5:0]  active_count;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    pwr_en_sequencer #(.NUM_MODULES(32), .DWELL_W(32)) dut (
        .clk100m      (clk100m),
        .rstn         (rstn),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .dwell_cycles (dwell_cycles),
        .pwr_en_out   (pwr_en_out),
        .active_count (active_count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk100m = ~clk100m;

    function automatic logic [31:0] thermo_exp(input int n);
        logic [63:0] v;
        v = (64'd1 << n) - 64'd1;
        return v[31:0];
    endfunction

    task automatic test_reset();
        rstn = 1'b0; start = 0; stop = 0; mode = 0; dwell_cycles = 0;
        repeat (3) @(negedge clk100m);
        checks++;
        if (pwr_en_out !== 32'd0 || active_count !== 6'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset pwr=%h cnt=%0d busy=%b done=%b exp all 0",
                     pwr_en_out, active_count, busy, done);
        end
        rstn = 1'b1;
        @(negedge clk100m);
        checks++;
        if (busy !== 1'b0 || pwr_en_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_release busy=%b pwr=%h exp 0 0",
                     busy, pwr_en_out);
        end
    endtask

    task automatic test_thermo();
        logic [31:0] ep;
        int          ec, p;
        @(negedge clk100m);
        start = 1; mode = 2'd0; dwell_cycles = 32'd2;
        for (int c = 1; c <= 128; c++) begin
            @(negedge clk100m);
            start = 0;
            if (c <= 126) begin
                p  = (c - 1) / 2;
                ec = (p < 32) ? p + 1 : 63 - p;
                ep = thermo_exp(ec);
            end else begin
                ec = 0; ep = 0;
            end
            checks++;
            if (pwr_en_out !== ep || active_count !== 6'(ec) ||
                busy !== (c <= 126) || done !== (c == 127)) begin
                failures++;
                $display("FAIL thermo c=%0d pwr=%h cnt=%0d busy=%b done=%b exp %h %0d %b %b",
                         c, pwr_en_out, active_count, busy, done,
                         ep, ec, (c <= 126), (c == 127));
            end
        end
    endtask

    task automatic test_walk_ignore_start();
        logic [31:0] ep;
        for (int c = 0; c <= 98; c++) begin
            if (c == 0) begin
                @(negedge clk100m);
                start = 1; mode = 2'd1; dwell_cycles = 32'd3;
            end else begin
                @(negedge clk100m);
                start = (c == 10);
                if (c == 10) begin mode = 2'd2; dwell_cycles = 32'd1; end
                ep = (c <= 96) ? (32'd1 << ((c - 1) / 3)) : 32'd0;
                checks++;
                if (pwr_en_out !== ep ||
                    active_count !== ((c <= 96) ? 6'd1 : 6'd0) ||
                    busy !== (c <= 96) || done !== (c == 97)) begin
                    failures++;
                    $display("FAIL walk c=%0d pwr=%h cnt=%0d busy=%b done=%b exp %h",
                             c, pwr_en_out, active_count, busy, done, ep);
                end
            end
        end
        start = 0;
    endtask

    task automatic test_allon_dwell0();
        @(negedge clk100m);
        start = 1; mode = 2'd2; dwell_cycles = 32'd0;
        @(negedge clk100m);
        start = 0;
        checks++;
        if (pwr_en_out !== 32'hFFFF_FFFF || active_count !== 6'd32 ||
            busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL allon_c1 pwr=%h cnt=%0d busy=%b exp ffffffff 32 1",
                     pwr_en_out, active_count, busy);
        end
        @(negedge clk100m);
        checks++;
        if (pwr_en_out !== 32'd0 || active_count !== 6'd0 ||
            busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL allon_c2 pwr=%h cnt=%0d busy=%b done=%b exp 0 0 0 1",
                     pwr_en_out, active_count, busy, done);
        end
        @(negedge clk100m);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL allon_c3 done=%b exp 0", done);
        end
    endtask

    task automatic test_stop();
        logic seen_bad;
        @(negedge clk100m);
        start = 1; mode = 2'd0; dwell_cycles = 32'd4;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk100m);
            start = 0;
        end
        checks++;
        if (pwr_en_out !== thermo_exp(5) || busy !== 1'b1) begin
            failures++;
            $display("FAIL stop_pre pwr=%h busy=%b exp %h 1",
                     pwr_en_out, busy, thermo_exp(5));
        end
        stop = 1; start = 1; mode = 2'd2; dwell_cycles = 32'd1;
        @(negedge clk100m);
        stop = 0; start = 0;
        checks++;
        if (pwr_en_out !== 32'd0 || busy !== 1'b0 ||
            done !== 1'b0 || active_count !== 6'd0) begin
            failures++;
            $display("FAIL stop_c21 pwr=%h busy=%b done=%b exp 0 0 0",
                     pwr_en_out, busy, done);
        end
        seen_bad = 0;
        repeat (10) begin
            @(negedge clk100m);
            if (busy !== 1'b0 || done !== 1'b0 || pwr_en_out !== 32'd0)
                seen_bad = 1;
        end
        checks++;
        if (seen_bad !== 1'b0) begin
            failures++;
            $display("FAIL stop_after got activity=%b exp 0", seen_bad);
        end
        // stop with start in idle: start must lose
        @(negedge clk100m);
        stop = 1; start = 1; mode = 2'd2;
        @(negedge clk100m);
        stop = 0; start = 0;
        checks++;
        if (busy !== 1'b0 || pwr_en_out !== 32'd0) begin
            failures++;
            $display("FAIL stop_idle busy=%b pwr=%h exp 0 0", busy, pwr_en_out);
        end
    endtask

    task automatic test_rsvd();
        logic seen_bad;
        @(negedge clk100m);
        start = 1; mode = 2'd3; dwell_cycles = 32'd2;
        seen_bad = 0;
        repeat (5) begin
            @(negedge clk100m);
            start = 0;
            if (busy !== 1'b0 || pwr_en_out !== 32'd0 || done !== 1'b0)
                seen_bad = 1;
        end
        checks++;
        if (seen_bad !== 1'b0) begin
            failures++;
            $display("FAIL rsvd got activity=%b exp 0", seen_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        @(negedge clk100m);
        start = 1; mode = 2'd1; dwell_cycles = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk100m);
            start = 0;
        end
        checks++;
        if (pwr_en_out !== 32'h8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre pwr=%h busy=%b exp 00000008 1",
                     pwr_en_out, busy);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (pwr_en_out !== 32'd0 || active_count !== 6'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async pwr=%h cnt=%0d busy=%b done=%b exp 0",
                     pwr_en_out, active_count, busy, done);
        end
        seen_done = 0;
        repeat (2) begin
            @(negedge clk100m);
            if (done !== 1'b0) seen_done = 1;
        end
        rstn  = 1'b1;
        start = 1; mode = 2'd2; dwell_cycles = 32'd0;
        @(negedge clk100m);
        start = 0;
        if (done !== 1'b0) seen_done = 1;
        checks++;
        if (pwr_en_out !== 32'hFFFF_FFFF || busy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_restart pwr=%h busy=%b exp ffffffff 1",
                     pwr_en_out, busy);
        end
        @(negedge clk100m);
        checks++;
        if (done !== 1'b1 || pwr_en_out !== 32'd0) begin
            failures++;
            $display("FAIL rmid_done done=%b pwr=%h exp 1 0", done, pwr_en_out);
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL rmid_nodone spurious=%b exp 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_thermo();
        test_walk_ignore_start();
        test_allon_dwell0();
        test_stop();
        test_rsvd();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
